// File: rtl/data_memory_arbiter.sv
// Core/DMA arbiter in front of a 1024x32 data memory, one transaction in flight.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin ties; otherwise core has fixed priority.
module data_memory_arbiter (
    input  logic        clock,
    input  logic        reset,

    input  logic        coreReq,
    input  logic        coreWrite,
    input  logic [2:0]  coreFunc3,
    input  logic [31:0] coreAddress,
    input  logic [31:0] coreWriteData,
    output logic        coreReady,
    output logic        coreReadValid,
    output logic [31:0] coreReadData,
    output logic        coreError,

    input  logic        dmaReq,
    input  logic        dmaWrite,
    input  logic [2:0]  dmaFunc3,
    input  logic [31:0] dmaAddress,
    input  logic [31:0] dmaWriteData,
    output logic        dmaReady,
    output logic        dmaReadValid,
    output logic [31:0] dmaReadData,
    output logic        dmaError,

    output logic        memoryReadEnable,
    output logic        memoryWriteEnable,
    output logic [2:0]  memoryFunc3,
    output logic [31:0] memoryAddress,
    output logic [31:0] memoryWriteData,
    input  logic [31:0] memoryReadData
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic OWNER_CORE = 1'b0;
    localparam logic OWNER_DMA  = 1'b1;

    state_t      state_q;
    logic        owner_q;
    logic        write_q;
    logic        misaligned_q;
    logic [2:0]  func3_q;
    logic [31:0] address_q;
    logic [31:0] writeData_q;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic        lastWinner_q;
`endif

    logic        coreValid_q;
    logic        coreError_q;
    logic [31:0] coreData_q;
    logic        dmaValid_q;
    logic        dmaError_q;
    logic [31:0] dmaData_q;

    logic        anyReq;
    logic        pickDma_d;
    logic        grant_d;
    logic        selWrite_d;
    logic        selMisaligned_d;
    logic [2:0]  selFunc3_d;
    logic [31:0] selAddress_d;
    logic [31:0] selWriteData_d;
    logic        inAccess;
    logic [31:0] respData;

    always_comb begin
        anyReq = coreReq | dmaReq;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
        pickDma_d = dmaReq & (~coreReq | (lastWinner_q == OWNER_CORE));
`else
        pickDma_d = dmaReq & ~coreReq;
`endif
        // Grants are suppressed while reset is held so Ready stays low.
        grant_d        = (state_q == IDLE) & anyReq & ~reset;
        selWrite_d     = pickDma_d ? dmaWrite     : coreWrite;
        selFunc3_d     = pickDma_d ? dmaFunc3     : coreFunc3;
        selAddress_d   = pickDma_d ? dmaAddress   : coreAddress;
        selWriteData_d = pickDma_d ? dmaWriteData : coreWriteData;
        selMisaligned_d =
            ((selFunc3_d[1:0] == 2'b10) & (selAddress_d[1:0] != 2'b00)) |
            ((selFunc3_d[1:0] == 2'b01) & selAddress_d[0]);
    end

    always_comb begin
        inAccess = (state_q == ACCESS);
        respData = (~write_q & ~misaligned_q) ? memoryReadData : 32'h0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= OWNER_CORE;
            write_q      <= 1'b0;
            misaligned_q <= 1'b0;
            func3_q      <= 3'b000;
            address_q    <= 32'h0;
            writeData_q  <= 32'h0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            lastWinner_q <= OWNER_DMA;
`endif
            coreValid_q  <= 1'b0;
            coreError_q  <= 1'b0;
            coreData_q   <= 32'h0;
            dmaValid_q   <= 1'b0;
            dmaError_q   <= 1'b0;
            dmaData_q    <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        owner_q      <= pickDma_d;
                        write_q      <= selWrite_d;
                        misaligned_q <= selMisaligned_d;
                        func3_q      <= selFunc3_d;
                        address_q    <= selAddress_d;
                        writeData_q  <= selWriteData_d;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                        lastWinner_q <= pickDma_d;
`endif
                        state_q      <= ACCESS;
                    end
                end
                ACCESS: begin
                    coreValid_q <= (owner_q == OWNER_CORE);
                    coreError_q <= (owner_q == OWNER_CORE) & misaligned_q;
                    coreData_q  <= (owner_q == OWNER_CORE) ? respData : 32'h0;
                    dmaValid_q  <= (owner_q == OWNER_DMA);
                    dmaError_q  <= (owner_q == OWNER_DMA) & misaligned_q;
                    dmaData_q   <= (owner_q == OWNER_DMA) ? respData : 32'h0;
                    state_q     <= RESP;
                end
                RESP: begin
                    coreValid_q <= 1'b0;
                    coreError_q <= 1'b0;
                    coreData_q  <= 32'h0;
                    dmaValid_q  <= 1'b0;
                    dmaError_q  <= 1'b0;
                    dmaData_q   <= 32'h0;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign coreReady     = grant_d & ~pickDma_d;
    assign dmaReady      = grant_d & pickDma_d;
    assign coreReadValid = coreValid_q;
    assign coreError     = coreError_q;
    assign coreReadData  = coreData_q;
    assign dmaReadValid  = dmaValid_q;
    assign dmaError      = dmaError_q;
    assign dmaReadData   = dmaData_q;

    // Memory bus is only non-zero in ACCESS; misaligned accesses never strobe.
    assign memoryReadEnable  = inAccess & ~write_q & ~misaligned_q;
    assign memoryWriteEnable = inAccess & write_q & ~misaligned_q;
    assign memoryFunc3       = inAccess ? func3_q     : 3'b000;
    assign memoryAddress     = inAccess ? address_q   : 32'h0;
    assign memoryWriteData   = inAccess ? writeData_q : 32'h0;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: directed latency/error/reset cases plus
// randomized traffic against a transaction-level reference model.
module tb_data_memory_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        coreReq, coreWrite;
    logic [2:0]  coreFunc3;
    logic [31:0] coreAddress, coreWriteData;
    logic        coreReady, coreReadValid, coreError;
    logic [31:0] coreReadData;
    logic        dmaReq, dmaWrite;
    logic [2:0]  dmaFunc3;
    logic [31:0] dmaAddress, dmaWriteData;
    logic        dmaReady, dmaReadValid, dmaError;
    logic [31:0] dmaReadData;
    logic        memoryReadEnable, memoryWriteEnable;
    logic [2:0]  memoryFunc3;
    logic [31:0] memoryAddress, memoryWriteData, memoryReadData;

    logic [31:0] dev_mem [0:1023];
    logic [31:0] ref_mem [0:1023];

    int   total = 0;
    int   bad   = 0;
    logic last_dma;

    logic        rdy, re, we, rv, er, qt;
    logic [31:0] ma, mw, rd;

    always #5 clock = ~clock;

    data_memory_arbiter dut (
        .clock(clock), .reset(reset),
        .coreReq(coreReq), .coreWrite(coreWrite), .coreFunc3(coreFunc3),
        .coreAddress(coreAddress), .coreWriteData(coreWriteData),
        .coreReady(coreReady), .coreReadValid(coreReadValid),
        .coreReadData(coreReadData), .coreError(coreError),
        .dmaReq(dmaReq), .dmaWrite(dmaWrite), .dmaFunc3(dmaFunc3),
        .dmaAddress(dmaAddress), .dmaWriteData(dmaWriteData),
        .dmaReady(dmaReady), .dmaReadValid(dmaReadValid),
        .dmaReadData(dmaReadData), .dmaError(dmaError),
        .memoryReadEnable(memoryReadEnable), .memoryWriteEnable(memoryWriteEnable),
        .memoryFunc3(memoryFunc3), .memoryAddress(memoryAddress),
        .memoryWriteData(memoryWriteData), .memoryReadData(memoryReadData)
    );

    function automatic logic [31:0] merge_store(input logic [31:0] old,
        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        r = old;
        case (f3[1:0])
            2'b00:   r[{a[1:0], 3'b000} +: 8] = d[7:0];
            2'b01:   r[{a[1], 4'b0000} +: 16] = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic misal(input logic [2:0] f3, input logic [31:0] a);
        return ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00)) ||
               ((f3[1:0] == 2'b01) && a[0]);
    endfunction

    function automatic logic [2:0] pick_f3(input int k);
        case (k)
            0: return 3'b000;
            1: return 3'b001;
            2: return 3'b010;
            3: return 3'b100;
            default: return 3'b101;
        endcase
    endfunction

    assign memoryReadData = dev_mem[memoryAddress[11:2]];

    always @(posedge clock)
        if (memoryWriteEnable)
            dev_mem[memoryAddress[11:2]] <= merge_store(dev_mem[memoryAddress[11:2]],
                memoryFunc3, memoryAddress, memoryWriteData);

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        coreReq = 0; coreWrite = 0; coreFunc3 = 0; coreAddress = 0; coreWriteData = 0;
        dmaReq = 0; dmaWrite = 0; dmaFunc3 = 0; dmaAddress = 0; dmaWriteData = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        step();
        reset = 1'b0;
        step();
        last_dma = 1'b1;
    endtask

    task automatic run_one(input logic dma, input logic wr, input logic [2:0] f3,
        input logic [31:0] a, input logic [31:0] wd,
        output logic o_rdy, output logic o_re, output logic o_we,
        output logic [31:0] o_ma, output logic [31:0] o_mw,
        output logic o_rv, output logic [31:0] o_rd, output logic o_er,
        output logic o_qt);
        if (dma) begin
            dmaReq = 1; dmaWrite = wr; dmaFunc3 = f3; dmaAddress = a; dmaWriteData = wd;
        end else begin
            coreReq = 1; coreWrite = wr; coreFunc3 = f3; coreAddress = a; coreWriteData = wd;
        end
        #1;
        o_rdy = dma ? dmaReady : coreReady;
        o_qt  = ((dma ? coreReady : dmaReady) === 1'b0);
        step();
        o_qt = o_qt && (coreReady === 1'b0) && (dmaReady === 1'b0);
        coreReq = 0;
        dmaReq  = 0;
        o_re = memoryReadEnable;
        o_we = memoryWriteEnable;
        o_ma = memoryAddress;
        o_mw = memoryWriteData;
        step();
        o_rv = dma ? dmaReadValid : coreReadValid;
        o_rd = dma ? dmaReadData  : coreReadData;
        o_er = dma ? dmaError     : coreError;
        o_qt = o_qt && (memoryReadEnable === 1'b0) && (memoryWriteEnable === 1'b0) &&
               (memoryAddress === 32'h0) &&
               ((dma ? coreReadValid : dmaReadValid) === 1'b0) &&
               ((dma ? coreReadData  : dmaReadData)  === 32'h0) &&
               ((dma ? coreError     : dmaError)     === 1'b0);
        step();
        o_qt = o_qt && (coreReadValid === 1'b0) && (dmaReadValid === 1'b0);
        idle_inputs();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        coreReq = 1'b1;
        dmaReq  = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        total++;
        if ({coreReady, dmaReady} !== 2'b00) begin
            bad++;
            $display("FAIL reset_ready: got %b want 00", {coreReady, dmaReady});
        end
        idle_inputs();
        #1;
        total++;
        if ({coreReadValid, dmaReadValid, coreError, dmaError,
             memoryReadEnable, memoryWriteEnable} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 000000", {coreReadValid, dmaReadValid,
                coreError, dmaError, memoryReadEnable, memoryWriteEnable});
        end
        total++;
        if ({coreReadData, dmaReadData} !== 64'h0) begin
            bad++;
            $display("FAIL reset_rdata: got %h want 0", {coreReadData, dmaReadData});
        end
        total++;
        if ({memoryFunc3, memoryAddress, memoryWriteData} !== 67'h0) begin
            bad++;
            $display("FAIL reset_membus: got %h want 0", {memoryFunc3, memoryAddress, memoryWriteData});
        end
        reset = 1'b0;
        step();
        last_dma = 1'b1;
    endtask

    task automatic test_core_load();
        dev_mem[4] <= 32'h8000_00FF;
        ref_mem[4] = 32'h8000_00FF;
        #1;
        run_one(1'b0, 1'b0, 3'b010, 32'h10, 32'h0, rdy, re, we, ma, mw, rv, rd, er, qt);
        last_dma = 1'b0;
        total++;
        if (rdy !== 1'b1) begin bad++; $display("FAIL core_load_ready: got %b want 1", rdy); end
        total++;
        if ({re, we} !== 2'b10) begin bad++; $display("FAIL core_load_strobe: got %b want 10", {re, we}); end
        total++;
        if (ma !== 32'h10) begin bad++; $display("FAIL core_load_addr: got %h want 00000010", ma); end
        total++;
        if ({rv, er} !== 2'b10) begin bad++; $display("FAIL core_load_resp: got %b want 10", {rv, er}); end
        total++;
        if (rd !== 32'h8000_00FF) begin bad++; $display("FAIL core_load_data: got %h want 800000ff", rd); end
        total++;
        if (qt !== 1'b1) begin bad++; $display("FAIL core_load_quiet: got %b want 1", qt); end
    endtask

    task automatic test_dma_store();
        run_one(1'b1, 1'b1, 3'b000, 32'h24, 32'hAB, rdy, re, we, ma, mw, rv, rd, er, qt);
        last_dma = 1'b1;
        ref_mem[9] = merge_store(ref_mem[9], 3'b000, 32'h24, 32'hAB);
        total++;
        if (rdy !== 1'b1) begin bad++; $display("FAIL dma_store_ready: got %b want 1", rdy); end
        total++;
        if ({re, we} !== 2'b01) begin bad++; $display("FAIL dma_store_strobe: got %b want 01", {re, we}); end
        total++;
        if ({ma, mw} !== {32'h24, 32'hAB}) begin
            bad++; $display("FAIL dma_store_bus: got %h/%h want 00000024/000000ab", ma, mw);
        end
        total++;
        if ({rv, er, rd} !== {2'b10, 32'h0}) begin
            bad++; $display("FAIL dma_store_resp: got %b/%b/%h want 1/0/0", rv, er, rd);
        end
        total++;
        if (qt !== 1'b1) begin bad++; $display("FAIL dma_store_quiet: got %b want 1", qt); end
    endtask

    task automatic test_misaligned();
        run_one(1'b0, 1'b0, 3'b010, 32'h6, 32'h0, rdy, re, we, ma, mw, rv, rd, er, qt);
        last_dma = 1'b0;
        total++;
        if ({re, we} !== 2'b00) begin bad++; $display("FAIL mis_lw_strobe: got %b want 00", {re, we}); end
        total++;
        if ({rv, er, rd} !== {2'b11, 32'h0}) begin
            bad++; $display("FAIL mis_lw_resp: got %b/%b/%h want 1/1/0", rv, er, rd);
        end
        run_one(1'b1, 1'b1, 3'b001, 32'h3, 32'h1234, rdy, re, we, ma, mw, rv, rd, er, qt);
        last_dma = 1'b1;
        total++;
        if ({re, we} !== 2'b00) begin bad++; $display("FAIL mis_sh_strobe: got %b want 00", {re, we}); end
        total++;
        if ({rv, er, rd, qt} !== {2'b11, 32'h0, 1'b1}) begin
            bad++; $display("FAIL mis_sh_resp: got %b/%b/%h/%b want 1/1/0/1", rv, er, rd, qt);
        end
    endtask

    task automatic test_arbitration();
        do_reset();
        coreReq = 1; coreWrite = 0; coreFunc3 = 3'b010; coreAddress = 32'h100;
        dmaReq  = 1; dmaWrite  = 0; dmaFunc3  = 3'b010; dmaAddress  = 32'h200;
        for (int g = 0; g < 4; g++) begin
            int   c;
            logic exp_d;
            c = 0;
            #1;
            while (!(coreReady || dmaReady) && c < 6) begin
                step();
                c++;
            end
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            exp_d = !last_dma;
`else
            exp_d = 1'b0;
`endif
            total++;
            if ({coreReady, dmaReady} !== (exp_d ? 2'b01 : 2'b10)) begin
                bad++;
                $display("FAIL grant_order_%0d: got %b want %b", g,
                    {coreReady, dmaReady}, (exp_d ? 2'b01 : 2'b10));
            end
            last_dma = exp_d;
            step();
            step();
            step();
        end
        idle_inputs();
        step();
        step();
        step();
    endtask

    task automatic test_reset_in_access();
        logic seen;
        coreReq = 1; coreWrite = 0; coreFunc3 = 3'b010; coreAddress = 32'h40;
        #1;
        total++;
        if (coreReady !== 1'b1) begin bad++; $display("FAIL rst_acc_ready: got %b want 1", coreReady); end
        step();
        total++;
        if (memoryReadEnable !== 1'b1) begin
            bad++; $display("FAIL rst_acc_strobe: got %b want 1", memoryReadEnable);
        end
        reset = 1'b1;
        coreReq = 0;
        #1;
        total++;
        if ({coreReady, dmaReady, coreReadValid, dmaReadValid, coreError, dmaError,
             coreReadData, dmaReadData, memoryReadEnable, memoryWriteEnable,
             memoryFunc3, memoryAddress, memoryWriteData} !== 139'h0) begin
            bad++;
            $display("FAIL rst_acc_outputs: got re=%b addr=%h rv=%b want all 0",
                memoryReadEnable, memoryAddress, coreReadValid);
        end
        step();
        reset = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            step();
            if (coreReadValid || dmaReadValid) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL rst_acc_no_resp: got %b want 0", seen); end
        last_dma = 1'b1;
        coreReq = 1; coreFunc3 = 3'b010; coreAddress = 32'h80;
        dmaReq  = 1; dmaFunc3  = 3'b010; dmaAddress  = 32'h84;
        #1;
        total++;
        if ({coreReady, dmaReady} !== 2'b10) begin
            bad++; $display("FAIL rst_acc_next_grant: got %b want 10", {coreReady, dmaReady});
        end
        last_dma = 1'b0;
        step();
        idle_inputs();
        step();
        step();
    endtask

    task automatic test_random();
        int          m, c;
        logic        pend_c, pend_d, exp_d, w, mis;
        logic [2:0]  f;
        logic [31:0] a, d, exp_rd;
        logic [67:0] got, want;
        for (int it = 0; it < 40; it++) begin
            m = $urandom_range(0, 2);
            pend_c = (m != 1);
            pend_d = (m != 0);
            coreWrite = 1'($urandom_range(0, 1));
            coreFunc3 = coreWrite ? pick_f3($urandom_range(0, 2)) : pick_f3($urandom_range(0, 4));
            coreAddress = 32'($urandom_range(0, 4095));
            coreWriteData = $urandom;
            dmaWrite = 1'($urandom_range(0, 1));
            dmaFunc3 = dmaWrite ? pick_f3($urandom_range(0, 2)) : pick_f3($urandom_range(0, 4));
            dmaAddress = 32'($urandom_range(0, 4095));
            dmaWriteData = $urandom;
            coreReq = pend_c;
            dmaReq  = pend_d;
            while (pend_c || pend_d) begin
                c = 0;
                #1;
                while (!(coreReady || dmaReady) && c < 5) begin
                    step();
                    c++;
                end
                if (pend_c && pend_d) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                    exp_d = !last_dma;
`else
                    exp_d = 1'b0;
`endif
                end else begin
                    exp_d = pend_d;
                end
                total++;
                if ({coreReady, dmaReady} !== (exp_d ? 2'b01 : 2'b10)) begin
                    bad++;
                    $display("FAIL rnd_grant_%0d: got %b want %b", it,
                        {coreReady, dmaReady}, (exp_d ? 2'b01 : 2'b10));
                end
                last_dma = exp_d;
                w = exp_d ? dmaWrite : coreWrite;
                f = exp_d ? dmaFunc3 : coreFunc3;
                a = exp_d ? dmaAddress : coreAddress;
                d = exp_d ? dmaWriteData : coreWriteData;
                mis = misal(f, a);
                step();
                if (exp_d) begin dmaReq = 0; pend_d = 0; end
                else begin coreReq = 0; pend_c = 0; end
                total++;
                if ({memoryReadEnable, memoryWriteEnable} !== {!w && !mis, w && !mis}) begin
                    bad++;
                    $display("FAIL rnd_strobe_%0d: got %b want %b", it,
                        {memoryReadEnable, memoryWriteEnable}, {!w && !mis, w && !mis});
                end
                if (!mis) begin
                    total++;
                    if (memoryAddress !== a) begin
                        bad++; $display("FAIL rnd_addr_%0d: got %h want %h", it, memoryAddress, a);
                    end
                end
                exp_rd = (!w && !mis) ? ref_mem[a[11:2]] : 32'h0;
                if (w && !mis) ref_mem[a[11:2]] = merge_store(ref_mem[a[11:2]], f, a, d);
                step();
                got = exp_d ? {dmaReadValid, dmaError, dmaReadData, coreReadValid, coreError, coreReadData}
                            : {coreReadValid, coreError, coreReadData, dmaReadValid, dmaError, dmaReadData};
                want = {1'b1, mis, exp_rd, 1'b0, 1'b0, 32'h0};
                total++;
                if (got !== want) begin
                    bad++; $display("FAIL rnd_resp_%0d: got %h want %h", it, got, want);
                end
                step();
            end
        end
        idle_inputs();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] v;
        idle_inputs();
        reset = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            v = $urandom;
            dev_mem[i] <= v;
            ref_mem[i] = v;
        end
        last_dma = 1'b1;
        test_reset();
        test_core_load();
        test_dma_store();
        test_misaligned();
        test_arbitration();
        test_reset_in_access();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
